// File: rtl/exmem_stage.sv
// ---------------------------------------------------------------------------
// exmem_stage -- execute / memory stage of the 3-stage pipeline.
//
// Runs the ALU, accesses the data memory, picks the write-back value and
// registers the write-back triple (RegWrite, WriteReg, WriteData) that goes
// back to the decode stage's register file.
//
// Optional feature macro: MUL_UNIT_EN
//   defined   : iterative shift-add multiplier (ALUctl 1000), MUL_STEPS cycles,
//               with `stall` holding the upstream stage while it runs.
//   undefined : no multiplier; ALUctl 1000 behaves as an unknown code
//               (result 0) and `stall` is tied low.
//
// Ports:
//   clk, rst (async, active-low)
//   Ctl_ALUSrc, Ctl_MemtoReg, Ctl_RegWrite, Ctl_MemWrite, Ctl_Branch1 : control
//   ALUctl[3:0], Rd_in[4:0], ReadData1_in, ReadData2_in, Immediate_in [31:0]
//   PC4_in[7:0]        : PC+4, used as the link value
//   stall              : upstream must hold its outputs this cycle
//   Ctl_RegWrite_out, WriteReg_out[4:0], WriteData_out[31:0] : write-back regs
// ---------------------------------------------------------------------------
module exmem_stage #(
  parameter int DMEM_AW   = 8,
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Ctl_ALUSrc,
  input  logic        Ctl_MemtoReg,
  input  logic        Ctl_RegWrite,
  input  logic        Ctl_MemWrite,
  input  logic        Ctl_Branch1,
  input  logic [3:0]  ALUctl,
  input  logic [4:0]  Rd_in,
  input  logic [31:0] ReadData1_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] Immediate_in,
  input  logic [7:0]  PC4_in,
  output logic        stall,
  output logic        Ctl_RegWrite_out,
  output logic [4:0]  WriteReg_out,
  output logic [31:0] WriteData_out
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic [31:0]        op_b;
  logic [31:0]        alu_result;
  logic [31:0]        mem_rdata;
  logic [31:0]        wb_data;
  logic [DMEM_AW-1:0] mem_addr;
  logic               mem_we;
  logic               is_mul;

  // ---------------- ALU ----------------
  // MUL is not computed here; the multiplier path supplies its own result.
  always_comb begin
    op_b       = Ctl_ALUSrc ? Immediate_in : ReadData2_in;
    alu_result = 32'd0;
    case (ALUctl)
      OP_AND: alu_result = ReadData1_in & op_b;
      OP_OR:  alu_result = ReadData1_in | op_b;
      OP_ADD: alu_result = ReadData1_in + op_b;
      OP_XOR: alu_result = ReadData1_in ^ op_b;
      OP_SLL: alu_result = ReadData1_in << op_b[4:0];
      OP_SRL: alu_result = ReadData1_in >> op_b[4:0];
      OP_SUB: alu_result = ReadData1_in - op_b;
      OP_SLT: alu_result = {31'd0, $signed(ReadData1_in) < $signed(op_b)};
      OP_NOR: alu_result = ~(ReadData1_in | op_b);
      default: alu_result = 32'd0;
    endcase
  end

  assign is_mul = (ALUctl == OP_MUL);

  // ---------------- Data memory ----------------
  // Asynchronous read so a load sees a store from the previous cycle.
  logic [31:0] dmem [0:(2**DMEM_AW)-1];

  assign mem_addr  = alu_result[DMEM_AW+1:2];
  assign mem_rdata = dmem[mem_addr];

  always_ff @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= ReadData2_in;
  end

  // Link value has priority over memory data, which has priority over ALU.
  always_comb begin
    if (Ctl_Branch1)       wb_data = {24'd0, PC4_in};
    else if (Ctl_MemtoReg) wb_data = mem_rdata;
    else                   wb_data = alu_result;
  end

`ifdef MUL_UNIT_EN
  localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   mcand_reg;   // multiplicand, shifted left each step
  logic [31:0]   mplier_reg;  // multiplier, shifted right each step
  logic [31:0]   acc_reg;
  logic [31:0]   acc_next;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : 32'd0);

  // Stall covers the start cycle plus every BUSY step except the last, so the
  // upstream stage advances exactly on the edge that writes the product.
  assign stall = rst && (((state_reg == ST_IDLE) && is_mul) ||
                         ((state_reg == ST_BUSY) && (count_reg != LAST_STEP)));

  assign mem_we = Ctl_MemWrite && (state_reg == ST_IDLE) && !is_mul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      count_reg        <= '0;
      mcand_reg        <= 32'd0;
      mplier_reg       <= 32'd0;
      acc_reg          <= 32'd0;
      Ctl_RegWrite_out <= 1'b0;
      WriteReg_out     <= 5'd0;
      WriteData_out    <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (is_mul) begin
            mcand_reg        <= ReadData1_in;
            mplier_reg       <= op_b;
            acc_reg          <= 32'd0;
            count_reg        <= '0;
            state_reg        <= ST_BUSY;
            Ctl_RegWrite_out <= 1'b0;
          end else begin
            Ctl_RegWrite_out <= Ctl_RegWrite;
            WriteReg_out     <= Rd_in;
            WriteData_out    <= wb_data;
          end
        end
        default: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + CW'(1);
          if (count_reg == LAST_STEP) begin
            Ctl_RegWrite_out <= Ctl_RegWrite;
            WriteReg_out     <= Rd_in;
            WriteData_out    <= acc_next;
            state_reg        <= ST_IDLE;
          end else begin
            Ctl_RegWrite_out <= 1'b0;
          end
        end
      endcase
    end
  end
`else
  assign stall  = 1'b0;
  assign mem_we = Ctl_MemWrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Ctl_RegWrite_out <= 1'b0;
      WriteReg_out     <= 5'd0;
      WriteData_out    <= 32'd0;
    end else begin
      Ctl_RegWrite_out <= Ctl_RegWrite;
      WriteReg_out     <= Rd_in;
      WriteData_out    <= wb_data;
    end
  end
`endif

endmodule
